// File: rtl/bank_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// bank_ctrl_pkg
// Shared definitions for the SRAM bank sequencer: FSM state encoding, default
// phase lengths and small constant helpers used to size ports and counters.
// -----------------------------------------------------------------------------
package bank_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    SAMPLE  = 3'd2,
    SENSE   = 3'd3,
    RECOVER = 3'd4
  } state_t;

  localparam int DEF_N_BANK  = 4;
  localparam int DEF_PRE_CYC = 1;
  localparam int DEF_WR_CYC  = 1;
  localparam int DEF_SMP_CYC = 1;
  localparam int DEF_SA_CYC  = 1;

  // Bank-select width; a single bank still gets a 1-bit select.
  function automatic int bank_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bank_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// bank_seq_ctrl_if
// Request handshake plus per-bank SRAM control strobes.
//   req_valid/req_ready/req_we/req_bank : access request handshake
//   preb    : per-bank precharge, active-low
//   w_drv   : per-bank write-driver enable
//   sampleb : per-bank bitline sample, active-low
//   sa_en   : per-bank sense-amp enable
//   done    : one-cycle completion pulse
//   err     : one-cycle pulse for an out-of-range bank request
// master = requester side, slave = controller side.
// -----------------------------------------------------------------------------
interface bank_seq_ctrl_if
  import bank_ctrl_pkg::*;
#(
  parameter int N_BANK = DEF_N_BANK
);
  localparam int BW = bank_w(N_BANK);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [BW-1:0]     req_bank;
  logic [N_BANK-1:0] preb;
  logic [N_BANK-1:0] w_drv;
  logic [N_BANK-1:0] sampleb;
  logic [N_BANK-1:0] sa_en;
  logic              done;
  logic              err;

  modport master (
    output req_valid, req_we, req_bank,
    input  req_ready, preb, w_drv, sampleb, sa_en, done, err
  );

  modport slave (
    input  req_valid, req_we, req_bank,
    output req_ready, preb, w_drv, sampleb, sa_en, done, err
  );

endinterface

// File: rtl/phase_cnt.sv
// -----------------------------------------------------------------------------
// phase_cnt
// Loadable saturating down-counter timing each sequencer phase.
//   clk, rst  : clock, asynchronous active-high reset (clears to 0)
//   load      : load load_val on the next edge (has priority)
//   load_val  : value to load, i.e. phase length minus one
//   value     : current count
//   zero      : value == 0, marks the last cycle of a phase
// -----------------------------------------------------------------------------
module phase_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         zero
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (value != '0) begin
      value <= value - 1'b1;
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/bank_seq_ctrl.sv
// -----------------------------------------------------------------------------
// bank_seq_ctrl
// Sequences one SRAM bank through precharge / write or sample+sense / recovery
// for each accepted request.
//   clk  : sole clock, rising edge
//   rst  : asynchronous active-high reset; aborts any access, outputs idle
//   bus  : bank_seq_ctrl_if.slave (request handshake + per-bank strobes)
// Write : IDLE -> WRITE(WR_CYC) -> RECOVER(PRE_CYC) -> IDLE
// Read  : IDLE -> SAMPLE(SMP_CYC) -> SENSE(SA_CYC) -> RECOVER(PRE_CYC) -> IDLE
// Bad bank (req_bank >= N_BANK): IDLE -> RECOVER, err instead of done.
// -----------------------------------------------------------------------------
module bank_seq_ctrl
  import bank_ctrl_pkg::*;
#(
  parameter int N_BANK  = DEF_N_BANK,
  parameter int PRE_CYC = DEF_PRE_CYC,
  parameter int WR_CYC  = DEF_WR_CYC,
  parameter int SMP_CYC = DEF_SMP_CYC,
  parameter int SA_CYC  = DEF_SA_CYC
) (
  input logic             clk,
  input logic             rst,
  bank_seq_ctrl_if.slave  bus
);

  localparam int BW      = bank_w(N_BANK);
  localparam int MAX_CYC = max_int(max_int(PRE_CYC, WR_CYC), max_int(SMP_CYC, SA_CYC));
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // Counter reload values: phase length minus one, so zero marks the last cycle.
  localparam logic [CNT_W-1:0] LD_PRE = CNT_W'(PRE_CYC - 1);
  localparam logic [CNT_W-1:0] LD_WR  = CNT_W'(WR_CYC - 1);
  localparam logic [CNT_W-1:0] LD_SMP = CNT_W'(SMP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_SA  = CNT_W'(SA_CYC - 1);

  state_t            state;
  state_t            state_nxt;
  logic [BW-1:0]     bank_r;
  logic              accept;
  logic              bank_bad_in;
  logic              bank_bad_r;
  logic              first_rec;
  logic [N_BANK-1:0] sel;
  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_load_val;
  logic [CNT_W-1:0]  cnt_value;
  logic              cnt_zero;

  assign accept      = bus.req_valid && bus.req_ready;
  assign bank_bad_in = int'(bus.req_bank) >= N_BANK;
  assign bank_bad_r  = int'(bank_r) >= N_BANK;

  // The counter was just reloaded with LD_PRE on RECOVER entry, so this value
  // identifies the first recovery cycle without a separate flag.
  assign first_rec = (state == RECOVER) && (cnt_value == LD_PRE);

  phase_cnt #(
    .W (CNT_W)
  ) u_phase_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .value    (cnt_value),
    .zero     (cnt_zero)
  );

  // Target bank is captured once; the access direction is carried by the
  // state itself (WRITE vs SAMPLE), so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      bank_r <= bus.req_bank;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and counter reload on every state entry
  always_comb begin
    state_nxt    = state;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_load = 1'b1;
          if (bank_bad_in) begin
            state_nxt    = RECOVER;
            cnt_load_val = LD_PRE;
          end else if (bus.req_we) begin
            state_nxt    = WRITE;
            cnt_load_val = LD_WR;
          end else begin
            state_nxt    = SAMPLE;
            cnt_load_val = LD_SMP;
          end
        end
      end
      WRITE: begin
        if (cnt_zero) begin
          state_nxt    = RECOVER;
          cnt_load     = 1'b1;
          cnt_load_val = LD_PRE;
        end
      end
      SAMPLE: begin
        if (cnt_zero) begin
          state_nxt    = SENSE;
          cnt_load     = 1'b1;
          cnt_load_val = LD_SA;
        end
      end
      SENSE: begin
        if (cnt_zero) begin
          state_nxt    = RECOVER;
          cnt_load     = 1'b1;
          cnt_load_val = LD_PRE;
        end
      end
      RECOVER: begin
        if (cnt_zero) begin
          state_nxt    = IDLE;
          cnt_load     = 1'b1;
          cnt_load_val = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // One-hot select of the captured bank; empty for an out-of-range bank.
  always_comb begin
    sel = '0;
    if (!bank_bad_r) begin
      sel[bank_r] = 1'b1;
    end
  end

  // Outputs: only the selected bank ever leaves its idle values, and at most
  // one strobe group is active per state, so w_drv and sa_en never overlap.
  always_comb begin
    bus.req_ready = (state == IDLE) && !rst;
    bus.preb      = '0;
    bus.sampleb   = '1;
    bus.w_drv     = '0;
    bus.sa_en     = '0;
    bus.done      = 1'b0;
    bus.err       = 1'b0;
    case (state)
      WRITE: begin
        bus.preb  = sel;
        bus.w_drv = sel;
      end
      SAMPLE: begin
        bus.preb    = sel;
        bus.sampleb = ~sel;
      end
      SENSE: begin
        bus.preb  = sel;
        bus.sa_en = sel;
      end
      RECOVER: begin
        bus.done = first_rec && !bank_bad_r;
        bus.err  = first_rec && bank_bad_r;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/bank_seq_ctrl.md
BANK_SEQ_CTRL -- requirements
Module: bank_seq_ctrl

Interface
REQ-001 SHALL have parameter N_BANK, default 4, number of SRAM banks driven (>=1).
REQ-002 SHALL have parameter PRE_CYC, default 1, precharge-recovery cycles after every access (>=1).
REQ-003 SHALL have parameter WR_CYC, default 1, write-driver pulse cycles (>=1).
REQ-004 SHALL have parameter SMP_CYC, default 1, bitline sample cycles (>=1).
REQ-005 SHALL have parameter SA_CYC, default 1, sense-amp enable cycles (>=1).
REQ-006 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port req_valid, input, 1, access request.
REQ-009 SHALL have port req_ready, output, 1, controller accepts request.
REQ-010 SHALL have port req_we, input, 1, 1 = write, 0 = read.
REQ-011 SHALL have port req_bank, input, BW = max(1, clog2(N_BANK)), target bank.
REQ-012 SHALL have ports preb, w_drv, sampleb and sa_en, outputs, N_BANK each, per-bank precharge (active-low), write drive, sample (active-low) and sense enable.
REQ-013 SHALL have port done, output, 1, one-cycle completion pulse, and port err, output, 1, one-cycle bad-bank pulse.

Function
REQ-014 SHALL implement states IDLE, WRITE, SAMPLE, SENSE, RECOVER with one shared phase down-counter.
REQ-015 SHALL drive req_ready = 1 only in IDLE while rst is low; an access is accepted on a clock edge with req_valid & req_ready.
REQ-016 SHALL register req_we and req_bank on acceptance; input changes afterwards have no effect.
REQ-017 SHALL, in IDLE, drive every preb bit 0, sampleb bits 1, and w_drv and sa_en bits 0.
REQ-018 SHALL, on write accepted at edge T, be in WRITE for WR_CYC cycles: selected bank preb=1, w_drv=1.
REQ-019 SHALL, on read accepted at edge T, be in SAMPLE for SMP_CYC cycles (selected preb=1, sampleb=0), then SENSE for SA_CYC cycles (selected preb=1, sampleb=1, sa_en=1).
REQ-020 SHALL, after WRITE or SENSE, be in RECOVER for PRE_CYC cycles with all preb=0 and all other outputs idle, then return to IDLE.
REQ-021 SHALL hold all non-selected banks at idle values throughout.
REQ-022 SHALL assert done for exactly the first RECOVER cycle.
REQ-023 SHALL give write occupancy 1+WR_CYC+PRE_CYC cycles and read occupancy 1+SMP_CYC+SA_CYC+PRE_CYC cycles, edge-to-next-ready inclusive of the IDLE cycle.
REQ-024 SHALL accept req_bank >= N_BANK: no bank driven, err pulsed in the cycle after acceptance, state goes directly to RECOVER, no done.
REQ-025 SHALL never assert w_drv and sa_en, or preb=1 on two banks, in the same cycle.
REQ-026 SHALL size the counter to clog2(max phase param + 1) bits and reload it on every state entry.

Reset
REQ-027 SHALL, while rst is high, force IDLE, counter 0, done=0, err=0, req_ready=0, all preb=0, sampleb=1, and w_drv/sa_en=0, asynchronously.
REQ-028 SHALL abort any in-flight access on reset with no done, and resume in IDLE at the first edge after rst falls.

Structure
REQ-029 SHALL take the state encoding and default phase constants from package bank_ctrl_pkg.
REQ-030 SHALL place the loadable phase down-counter in sub-module phase_cnt (load, value, zero flag).

Verification
Use N_BANK=4, PRE_CYC=2, WR_CYC=3, SMP_CYC=1, SA_CYC=2.
REQ-031 SHALL check: after reset, write to bank 2 -> preb[2]=1 and w_drv[2]=1 for 3 cycles, then 2 RECOVER cycles, done in the first; req_ready returns 6 cycles after acceptance.
REQ-032 SHALL check: read of bank 1 -> sampleb[1]=0 for 1 cycle, then sa_en[1]=1 for 2 cycles, then RECOVER 2 cycles; other banks stay idle.
REQ-033 SHALL check: req_valid held high with alternating we/bank -> back-to-back accesses, each accepted only in IDLE, with no overlap of drive outputs.
REQ-034 SHALL check: with N_BANK=3, request to bank 3 -> err pulse, no preb/w_drv/sa_en activity, no done.
REQ-035 SHALL check: rst asserted mid-SENSE -> outputs idle immediately, no done, and a new request is accepted the first cycle after rst falls.
